reflet_uart_loader: RTL

Serial program loader for the 16-bit Reflet controller. It sits directly upstream of the instruction memory: it receives a framed program image over an 8N1 UART line and writes it word by word through the instruction memory write port. It raises `done` when a complete, checksum-valid image has been stored; `done` serves as the memory's ready signal that releases the CPU from reset.

---
 rtl/reflet_uart_loader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/reflet_uart_loader.sv
// Serial program loader: receives a framed 8N1 UART image and writes it
// word by word into the instruction memory, flagging done or error.
module reflet_uart_loader #(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600,
  parameter int unsigned inst_size = 128,
  parameter int unsigned addr_size = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [addr_size-1:0] mem_addr,
  output logic [15:0]          mem_data,
  output logic                 mem_write_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned BIT_P  = clk_freq / baud_rate;
  localparam int unsigned HALF_P = BIT_P / 2;
  localparam int unsigned CNT_W  = $clog2(BIT_P);

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHK,
    S_DONE,
    S_ERROR
  } ld_state_t;

  rx_state_t        rx_state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  ld_state_t        ld_state;
  logic [15:0]      len;
  logic [7:0]       sum;
  logic [7:0]       lo_byte;
  logic [addr_size-1:0] idx;

  logic [7:0]       sum_add;
  logic [15:0]      n_word;
  logic [16:0]      idx_next_ext;

  assign sum_add      = sum + rx_byte;
  assign n_word       = {rx_byte, len[7:0]};
  assign idx_next_ext = 17'(idx) + 17'd1;

  // UART receiver: synchroniser, start detect/glitch reject, centre sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= R_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= R_START;
            bit_cnt  <= CNT_W'(HALF_P - 1);
          end
        end
        R_START: begin
          if (bit_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= R_IDLE;
            end else begin
              rx_state <= R_DATA;
              bit_cnt  <= CNT_W'(BIT_P - 1);
              bit_idx  <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        R_DATA: begin
          if (bit_cnt == '0) begin
            shift   <= {rx_s2, shift[7:1]};
            bit_cnt <= CNT_W'(BIT_P - 1);
            if (bit_idx == 3'd7) begin
              rx_state <= R_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        R_STOP: begin
          if (bit_cnt == '0) begin
            if (rx_s2) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift;
            end else begin
              frame_err <= 1'b1;
            end
            rx_state <= R_IDLE;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Frame parser: length, data words, checksum; drives the memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state     <= S_LEN_LO;
      len          <= '0;
      sum          <= '0;
      lo_byte      <= '0;
      idx          <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_write_en <= 1'b0;
      if (ld_state != S_DONE && ld_state != S_ERROR) begin
        if (frame_err) begin
          ld_state <= S_ERROR;
          error    <= 1'b1;
          busy     <= 1'b0;
        end else if (byte_valid) begin
          case (ld_state)
            S_LEN_LO: begin
              len[7:0] <= rx_byte;
              sum      <= rx_byte;
              busy     <= 1'b1;
              ld_state <= S_LEN_HI;
            end
            S_LEN_HI: begin
              len <= n_word;
              sum <= sum_add;
              if (n_word > 16'(inst_size)) begin
                ld_state <= S_ERROR;
                error    <= 1'b1;
                busy     <= 1'b0;
              end else if (n_word == 16'd0) begin
                ld_state <= S_CHK;
              end else begin
                ld_state <= S_DATA_LO;
              end
            end
            S_DATA_LO: begin
              lo_byte  <= rx_byte;
              sum      <= sum_add;
              ld_state <= S_DATA_HI;
            end
            S_DATA_HI: begin
              mem_addr     <= idx;
              mem_data     <= {rx_byte, lo_byte};
              mem_write_en <= 1'b1;
              idx          <= idx + addr_size'(1);
              sum          <= sum_add;
              if (idx_next_ext == {1'b0, len}) begin
                ld_state <= S_CHK;
              end else begin
                ld_state <= S_DATA_LO;
              end
            end
            S_CHK: begin
              busy <= 1'b0;
              if (rx_byte == sum) begin
                ld_state <= S_DONE;
                done     <= 1'b1;
              end else begin
                ld_state <= S_ERROR;
                error    <= 1'b1;
              end
            end
            default: ld_state <= S_ERROR;
          endcase
        end
      end
    end
  end

endmodule
